// File: rtl/updi_uart_tx.sv
// updi_uart_tx
// Bit-level UPDI transmitter. Pops bytes from a show-ahead TX FIFO and
// serialises them as 8E2 frames (start, 8 data bits LSB first, even parity,
// two stop bits) on the single-wire UPDI line. Also produces a BREAK (line
// held low for BREAK_BITS bit times followed by two stop bits) on request.
// The pad enable is dropped whenever the sequencer is idle so the open-drain
// pad releases the line to its pull-up between frames.
//
// Timing: the pop strobe, busy and the sequencer state update on the same
// edge. The line register follows the sequencer one cycle later, so the line
// goes low the cycle after the pop strobe. frame_done is aligned with the
// line: it pulses in the first released cycle after the last stop bit.
module updi_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int BREAK_BITS   = 24,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT*BREAK_BITS+1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] uart_tx_fifo_data,
  input  logic       uart_tx_fifo_empty,
  output logic       uart_tx_fifo_rd_en,
  input  logic       break_req,
  output logic       updi_tx,
  output logic       updi_oe,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BRK    = 3'd5
  } state_t;

  // Counter reload values: the counter runs down to zero, so a load of N-1
  // gives a state that lasts exactly N cycles.
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(2*CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BRK_LOAD  = CNT_W'(BREAK_BITS*CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Even parity bit: makes the total count of ones over data + parity even.
  function automatic logic f_even_parity(input logic [7:0] d);
    f_even_parity = ^d;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_par;
  logic             r_pend;
  logic             r_rd_en;
  logic             r_busy;
  logic             r_done;
  logic             r_done_d;
  logic             r_tx;
  logic             r_oe;

  logic             w_tick;
  logic [CNT_W-1:0] w_cnt_dec;

  assign w_tick    = (r_cnt == CNT_ZERO);
  assign w_cnt_dec = r_cnt - CNT_ONE;

  // Sequencer: state, bit timing, shift register, BREAK pending flag and status strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_par   <= 1'b0;
      r_pend  <= 1'b0;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
      // A request arriving mid-frame is remembered; repeats are absorbed.
      r_pend  <= r_pend | break_req;
      case (r_state)
        S_IDLE: begin
          if (r_pend || break_req) begin
            // BREAK wins over a waiting byte; the byte is not popped.
            r_state <= S_BRK;
            r_cnt   <= BRK_LOAD;
            r_pend  <= 1'b0;
          end else if (!uart_tx_fifo_empty) begin
            r_rd_en <= 1'b1;
            r_shift <= uart_tx_fifo_data;
            r_par   <= f_even_parity(uart_tx_fifo_data);
            r_idx   <= 3'd0;
            r_state <= S_START;
            r_cnt   <= BIT_LOAD;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_state <= S_DATA;
            r_cnt   <= BIT_LOAD;
          end else begin
            r_cnt   <= w_cnt_dec;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_cnt   <= BIT_LOAD;
            if (r_idx == 3'd7) begin
              r_state <= S_PARITY;
            end else begin
              r_idx   <= r_idx + 3'd1;
            end
          end else begin
            r_cnt   <= w_cnt_dec;
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_state <= S_STOP;
            r_cnt   <= STOP_LOAD;
          end else begin
            r_cnt   <= w_cnt_dec;
          end
        end
        S_BRK: begin
          if (w_tick) begin
            r_state <= S_STOP;
            r_cnt   <= STOP_LOAD;
          end else begin
            r_cnt   <= w_cnt_dec;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_busy  <= r_pend | break_req;
          end else begin
            r_cnt   <= w_cnt_dec;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= CNT_ZERO;
          r_busy  <= r_pend | break_req;
        end
      endcase
    end
  end

  // Line driver: follows the sequencer one cycle behind so every state's full bit time appears on the pad
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx     <= 1'b1;
      r_oe     <= 1'b0;
      r_done_d <= 1'b0;
    end else begin
      r_done_d <= r_done;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          r_oe <= 1'b0;
        end
        S_START: begin
          r_tx <= 1'b0;
          r_oe <= 1'b1;
        end
        S_DATA: begin
          r_tx <= r_shift[0];
          r_oe <= 1'b1;
        end
        S_PARITY: begin
          r_tx <= r_par;
          r_oe <= 1'b1;
        end
        S_STOP: begin
          r_tx <= 1'b1;
          r_oe <= 1'b1;
        end
        S_BRK: begin
          r_tx <= 1'b0;
          r_oe <= 1'b1;
        end
        default: begin
          r_tx <= 1'b1;
          r_oe <= 1'b0;
        end
      endcase
    end
  end

  assign uart_tx_fifo_rd_en = r_rd_en;
  assign updi_tx            = r_tx;
  assign updi_oe            = r_oe;
  assign busy               = r_busy;
  assign frame_done         = r_done_d;

endmodule
